trigger_capture_ram: RTL and testbench
======================================

Name: trigger_capture_ram

Overview:
- Parametrised successor to the team's single-port capture RAM: a circular sample buffer with an arm/trigger/post-trigger state machine and an independent read-out port.
- Sits between the trigger/sample front end and the UART read-out engine.
- Continuously records pre-trigger history, freezes after a programmable number of post-trigger samples, then presents the capture oldest-first through a relative index.

Parameters:
DATA_WIDTH, 8, sample width in bits
ADDR_BITS, 13, log2 of buffer depth (DEPTH = 2**ADDR_BITS)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
arm  input  1  one-cycle pulse: clear status and start capturing
sample_valid  input  1  sample_data is written this cycle when capturing
sample_data  input  DATA_WIDTH  sample to store
trigger  input  1  trigger event, qualified by sample_valid
post_count  input  ADDR_BITS  samples to store after the trigger sample, sampled on arm
rd_en  input  1  read request
rd_index  input  ADDR_BITS  read position, 0 = oldest stored sample
rd_data  output  DATA_WIDTH  read result, 1-cycle latency, 0 when not read
armed  output  1  high in ARMED state
triggered  output  1  high in POST and DONE
done  output  1  high in DONE
wrapped  output  1  buffer has been filled at least once since arm
sample_count  output  ADDR_BITS+1  samples stored, saturates at DEPTH
trig_index  output  ADDR_BITS  read-order index of the trigger sample

Behaviour:
- Reset (asynchronous, active-high): state IDLE. wr_ptr, post counter, start pointer, trig_addr, sample_count, wrapped, trig_index and rd_data all 0. Memory contents are not cleared.
- States:
  - IDLE: no writes. arm -> ARMED.
  - ARMED: each sample_valid writes mem[wr_ptr] and increments wr_ptr modulo DEPTH. sample_valid && trigger -> POST, latching trig_addr = wr_ptr of that write.
  - POST: each sample_valid writes and decrements the post counter. When the write that exhausts the counter occurs -> DONE.
  - DONE: no writes. Hold all status. arm -> ARMED.
- post_count = 0: go straight from ARMED to DONE on the trigger sample.
- Latch post_count on arm. Clamp it to DEPTH-1 so the trigger sample is always retained.
- Wrap and fill:
  - wrapped sets when wr_ptr wraps from DEPTH-1 to 0.
  - sample_count increments per write and saturates at DEPTH.
- On entry to DONE:
  - start = wrapped ? wr_ptr(next) : 0.
  - trig_index = (trig_addr - start) mod DEPTH.
- Read-out:
  - Physical address = (start + rd_index) mod DEPTH.
  - rd_data registered one cycle after rd_en. rd_en low forces rd_data to 0 on the next edge.
  - Reads are legal in any state. Before DONE, start = 0.
  - Reads and writes target independent ports. A same-address read during a write returns old data (read-first).
- Status outputs are registered decodes of the state.
- arm in any state, including mid-POST: clear wr_ptr, sample_count, wrapped and trig_index, then enter ARMED next cycle. arm has priority over a coincident sample_valid, so that sample is dropped.
- trigger in IDLE or DONE, or without sample_valid, is ignored. trigger in POST is ignored.
- Asserting rst at any time returns to IDLE within the same cycle, asynchronously.

Decomposition:
- Package trigger_capture_pkg: state enum (IDLE, ARMED, POST, DONE) and a DEPTH helper function.
- One sub-module: sdp_ram.
  - Simple dual-port block RAM, parametrised DATA_WIDTH/ADDR_BITS, with RAM_STYLE block attribute.
  - Write port: we/waddr/wdata. Registered read port: re/raddr/rdata, zero when re low.
  - Top level holds the FSM, pointers and address arithmetic.

Test Plan:
All with DATA_WIDTH=8, ADDR_BITS=4 (DEPTH=16).
1. Reset: assert rst mid-cycle -> armed/triggered/done/wrapped=0, sample_count=0, rd_data=0 immediately.
2. arm with post_count=2. Write 0x10..0x14, trigger with 0x12 -> done high one cycle after 0x14 is written, sample_count=5, wrapped=0, trig_index=2. rd_index 0..4 returns 0x10..0x14 one cycle after each rd_en.
3. arm with post_count=2. Write 0x00..0x13, trigger with 0x11 -> wrapped=1, sample_count=16, trig_index=13. rd_index 0 returns 0x04, rd_index 15 returns 0x13.
4. trigger pulses while IDLE, and trigger with sample_valid=0 in ARMED -> no state change, triggered stays 0.
5. post_count=0, trigger on the third sample -> done one cycle after that write, trig_index=2, later samples not written.
6. arm mid-POST -> armed=1 next cycle, sample_count=0. rd_en low -> rd_data=0x00 next cycle.

Source files
------------

// File: rtl/trigger_capture_pkg.sv
// Shared types and helpers for the trigger capture RAM.
package trigger_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int unsigned depth_of(input int unsigned addr_bits);
      return 32'd1 << addr_bits;
   endfunction

endpackage

// File: rtl/trigger_capture_ram_sdp_ram.sv
// Simple dual-port block RAM: one write port, one registered read port.
module sdp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_BITS-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

   // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read-first: a same-address write in this cycle is not visible until the next read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
      else         rdata <= '0;
   end

endmodule

// File: rtl/trigger_capture_ram.sv
// Circular capture buffer with arm/trigger/post-trigger FSM and oldest-first read-out.
module trigger_capture_ram
   import trigger_capture_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_data,
   input  logic                  trigger,
   input  logic [ADDR_BITS-1:0]  post_count,
   input  logic                  rd_en,
   input  logic [ADDR_BITS-1:0]  rd_index,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  armed,
   output logic                  triggered,
   output logic                  done,
   output logic                  wrapped,
   output logic [ADDR_BITS:0]    sample_count,
   output logic [ADDR_BITS-1:0]  trig_index
);

   localparam int unsigned DEPTH = depth_of(ADDR_BITS);
   localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS+1)'(DEPTH);

   state_t                 state, state_nxt;
   logic [ADDR_BITS-1:0]   wr_ptr, wr_ptr_nxt;
   logic [ADDR_BITS-1:0]   post_cnt, post_nxt;
   logic [ADDR_BITS-1:0]   start_ptr, start_nxt;
   logic [ADDR_BITS-1:0]   trig_addr, trig_addr_nxt;
   logic [ADDR_BITS-1:0]   trig_index_nxt;
   logic [ADDR_BITS:0]     cnt_nxt;
   logic                   wrapped_nxt;
   logic                   we;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt      = state;
      wr_ptr_nxt     = wr_ptr;
      post_nxt       = post_cnt;
      start_nxt      = start_ptr;
      trig_addr_nxt  = trig_addr;
      trig_index_nxt = trig_index;
      cnt_nxt        = sample_count;
      wrapped_nxt    = wrapped;
      we             = 1'b0;

      if (arm) begin
         // post_count is ADDR_BITS wide, so it is already bounded to DEPTH-1.
         state_nxt      = ST_ARMED;
         wr_ptr_nxt     = '0;
         post_nxt       = post_count;
         start_nxt      = '0;
         trig_index_nxt = '0;
         cnt_nxt        = '0;
         wrapped_nxt    = 1'b0;
      end else if (sample_valid && (state == ST_ARMED || state == ST_POST)) begin
         we         = 1'b1;
         wr_ptr_nxt = wr_ptr + 1'b1;
         if (wr_ptr == '1)               wrapped_nxt = 1'b1;
         if (sample_count != DEPTH_CNT)  cnt_nxt     = sample_count + 1'b1;

         if (state == ST_ARMED) begin
            if (trigger) begin
               trig_addr_nxt = wr_ptr;
               state_nxt     = (post_cnt == '0) ? ST_DONE : ST_POST;
            end
         end else begin
            post_nxt = post_cnt - 1'b1;
            if (post_cnt == ADDR_BITS'(1)) state_nxt = ST_DONE;
         end

         // Freeze the read-out origin at the oldest surviving sample.
         if (state_nxt == ST_DONE) begin
            start_nxt      = wrapped_nxt ? wr_ptr_nxt : '0;
            trig_index_nxt = trig_addr_nxt - start_nxt;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         wr_ptr       <= '0;
         post_cnt     <= '0;
         start_ptr    <= '0;
         trig_addr    <= '0;
         trig_index   <= '0;
         sample_count <= '0;
         wrapped      <= 1'b0;
         armed        <= 1'b0;
         triggered    <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         wr_ptr       <= wr_ptr_nxt;
         post_cnt     <= post_nxt;
         start_ptr    <= start_nxt;
         trig_addr    <= trig_addr_nxt;
         trig_index   <= trig_index_nxt;
         sample_count <= cnt_nxt;
         wrapped      <= wrapped_nxt;
         armed        <= (state_nxt == ST_ARMED);
         triggered    <= (state_nxt == ST_POST) || (state_nxt == ST_DONE);
         done         <= (state_nxt == ST_DONE);
      end
   end

   sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (ADDR_BITS)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (wr_ptr),
      .wdata (sample_data),
      .re    (rd_en),
      .raddr (start_ptr + rd_index),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_trigger_capture_ram.sv
// Directed self-checking bench for trigger_capture_ram (DEPTH = 16).
module tb_trigger_capture_ram;

   localparam int DW = 8;
   localparam int AB = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm;
   logic          sample_valid;
   logic [DW-1:0] sample_data;
   logic          trigger;
   logic [AB-1:0] post_count;
   logic          rd_en;
   logic [AB-1:0] rd_index;
   logic [DW-1:0] rd_data;
   logic          armed;
   logic          triggered;
   logic          done;
   logic          wrapped;
   logic [AB:0]   sample_count;
   logic [AB-1:0] trig_index;

   int errors = 0;
   int checks = 0;

   trigger_capture_ram #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
      .clk          (clk),
      .rst          (rst),
      .arm          (arm),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .trigger      (trigger),
      .post_count   (post_count),
      .rd_en        (rd_en),
      .rd_index     (rd_index),
      .rd_data      (rd_data),
      .armed        (armed),
      .triggered    (triggered),
      .done         (done),
      .wrapped      (wrapped),
      .sample_count (sample_count),
      .trig_index   (trig_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic [AB-1:0] pc);
      arm = 1'b1; post_count = pc;
      step();
      arm = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic t);
      sample_valid = 1'b1; sample_data = d; trigger = t;
      step();
      sample_valid = 1'b0; trigger = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [AB-1:0] idx, input logic [DW-1:0] exp);
      rd_en = 1'b1; rd_index = idx;
      step();
      rd_en = 1'b0;
      check(tag, rd_data, exp);
   endtask

   initial begin
      rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample_data = '0;
      trigger = 1'b0; post_count = '0; rd_en = 1'b0; rd_index = '0;
      step(); step();
      rst = 1'b0;
      check("rst_armed", armed, 0);
      check("rst_done", done, 0);
      check("rst_count", sample_count, 0);
      check("rst_rd_data", rd_data, 0);

      // Short capture, no wrap
      do_arm(4'd2);
      check("t2_armed", armed, 1);
      send(8'h10, 1'b0);
      send(8'h11, 1'b0);
      send(8'h12, 1'b1);
      check("t2_triggered", triggered, 1);
      check("t2_not_done", done, 0);
      send(8'h13, 1'b0);
      check("t2_still_post", done, 0);
      send(8'h14, 1'b0);
      check("t2_done", done, 1);
      check("t2_armed_low", armed, 0);
      check("t2_count", sample_count, 5);
      check("t2_wrapped", wrapped, 0);
      check("t2_trig_index", trig_index, 2);
      for (int i = 0; i < 5; i++)
         read_chk($sformatf("t2_rd%0d", i), AB'(i), DW'(8'h10 + i));

      // Asynchronous reset mid-cycle with rd_data holding a value
      rd_en = 1'b1; rd_index = 4'd4;
      step();
      check("t1_pre_rd", rd_data, 8'h14);
      #2 rst = 1'b1;
      #1;
      check("t1_rd_data", rd_data, 0);
      check("t1_done", done, 0);
      check("t1_triggered", triggered, 0);
      check("t1_count", sample_count, 0);
      check("t1_trig_index", trig_index, 0);
      rd_en = 1'b0;
      step();
      rst = 1'b0;

      // Wrapping capture
      do_arm(4'd2);
      for (int i = 0; i < 20; i++)
         send(DW'(i), i == 17);
      check("t3_done", done, 1);
      check("t3_wrapped", wrapped, 1);
      check("t3_count", sample_count, 16);
      check("t3_trig_index", trig_index, 13);
      read_chk("t3_rd0", 4'd0, 8'h04);
      read_chk("t3_rd13", 4'd13, 8'h11);
      read_chk("t3_rd15", 4'd15, 8'h13);

      // Ignored triggers
      rst = 1'b1; step(); rst = 1'b0;
      send(8'hAA, 1'b1);
      check("t4_idle_trig", triggered, 0);
      check("t4_idle_armed", armed, 0);
      check("t4_idle_count", sample_count, 0);
      do_arm(4'd1);
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      check("t4_novalid_trig", triggered, 0);
      check("t4_novalid_armed", armed, 1);

      // post_count = 0: done on the trigger sample itself
      do_arm(4'd0);
      send(8'hA0, 1'b0);
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b1);
      check("t5_done", done, 1);
      check("t5_trig_index", trig_index, 2);
      check("t5_count", sample_count, 3);
      send(8'hA3, 1'b0);
      check("t5_count_hold", sample_count, 3);
      read_chk("t5_rd0", 4'd0, 8'hA0);
      read_chk("t5_rd2", 4'd2, 8'hA2);
      read_chk("t5_rd3_old", 4'd3, 8'h13);

      // Re-arm during POST with a coincident sample that must be dropped
      do_arm(4'd3);
      send(8'hB0, 1'b0);
      send(8'hB1, 1'b1);
      send(8'hB2, 1'b0);
      check("t6_post", triggered, 1);
      check("t6_post_count", sample_count, 3);
      arm = 1'b1; post_count = 4'd3; sample_valid = 1'b1; sample_data = 8'hEE;
      step();
      arm = 1'b0; sample_valid = 1'b0;
      check("t6_armed", armed, 1);
      check("t6_trig_clr", triggered, 0);
      check("t6_count", sample_count, 0);
      send(8'hC0, 1'b0);
      check("t6_count1", sample_count, 1);
      read_chk("t6_rd0", 4'd0, 8'hC0);
      read_chk("t6_rd3_old", 4'd3, 8'hA3 ^ 8'hA3 ^ 8'h13);
      rd_en = 1'b0;
      step();
      check("t6_rd_idle", rd_data, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
